// File: rtl/rv32i_types.sv
// Shared renamer types: physical-register counts, phys-reg index type and the
// free-list pointer (wrap phase + index) with its increment helper.
package rv32i_types;

    localparam int NUM_PHYS_REGS = 64;
    localparam int NUM_ARCH_REGS = 32;
    localparam int PHYS_REG_BITS = $clog2(NUM_PHYS_REGS);

    // The free list holds every register not owned by the RRAT at reset.
    localparam int FL_DEPTH    = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int FL_IDX_BITS = $clog2(FL_DEPTH);
    localparam int FL_PTR_BITS = FL_IDX_BITS + 1;

    typedef logic [PHYS_REG_BITS-1:0] pd_t;

    // The phase bit flips each time the index wraps, which separates full from empty.
    typedef struct packed {
        logic                   phase;
        logic [FL_IDX_BITS-1:0] idx;
    } fl_ptr_t;

    function automatic fl_ptr_t fl_ptr_inc(input fl_ptr_t p);
        logic [FL_PTR_BITS-1:0] v;
        v = p;
        v = v + FL_PTR_BITS'(1);
        return fl_ptr_t'(v);
    endfunction

endpackage

// File: rtl/free_list.sv
// Physical-register free list: circular show-ahead FIFO of free phys-reg indices.
// The RRAT enqueues freed registers at commit, rename dequeues fresh ones, and a
// flush re-opens every register that is not held by the RRAT.
// Optional feature: define FREE_LIST_BYPASS_EN to forward an enqueue straight to
// deq_pd when the list is empty.
module free_list
    import rv32i_types::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enqueue,
    input  logic [PHYS_REG_BITS-1:0] enq_pd,
    input  logic                   dequeue,
    output logic [PHYS_REG_BITS-1:0] deq_pd,
    output logic                   deq_valid,
    input  logic                   flush,
    output logic [FL_PTR_BITS-1:0] free_count,
    output logic                   overflow
);

    pd_t     mem_q [FL_DEPTH];
    fl_ptr_t head_q, head_d;
    fl_ptr_t tail_q, tail_d;
    logic    overflow_q, overflow_d;

    logic    empty, full;
    logic    do_enq, do_deq;
    logic [FL_PTR_BITS-1:0] head_vec, tail_vec;

    assign empty = (head_q == tail_q);
    assign full  = (head_q.idx == tail_q.idx) && (head_q.phase != tail_q.phase);

    assign head_vec   = head_q;
    assign tail_vec   = tail_q;
    assign free_count = tail_vec - head_vec;
    assign overflow   = overflow_q;

    // Output selection, accept/reject decisions and next pointer values.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
        deq_pd     = mem_q[head_q.idx];
        deq_valid  = !empty;
        do_deq     = dequeue && !empty && !flush;
        do_enq     = enqueue && (!full || do_deq);
        overflow_d = overflow_q;
`ifdef FREE_LIST_BYPASS_EN
        if (empty && enqueue) begin
            deq_pd    = enq_pd;
            deq_valid = 1'b1;
            // Rename takes the forwarded register directly, so nothing is stored.
            if (dequeue && !flush) begin
                do_enq = 1'b0;
            end
        end
`endif
        if (enqueue && full && !do_deq) begin
            overflow_d = 1'b1;
        end

        tail_d = do_enq ? fl_ptr_inc(tail_q) : tail_q;
        head_d = do_deq ? fl_ptr_inc(head_q) : head_q;
        // Everything between the new tail and one lap back is free once the RRAT is the only mapping.
        if (flush) begin
            head_d = '{phase: ~tail_d.phase, idx: tail_d.idx};
        end
    end

    // Pointer and sticky-overflow registers; reset leaves the list full.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            head_q     <= '{phase: 1'b0, idx: '0};
            tail_q     <= '{phase: 1'b1, idx: '0};
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage; written only when an enqueue is accepted.
    always_ff @(posedge clk) begin
        // NOTE: the storage is reset deliberately: entry i must hold p(NUM_ARCH_REGS+i) so the list starts full.
        if (rst) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                mem_q[i] <= pd_t'(NUM_ARCH_REGS + i);
            end
        end else if (do_enq) begin
            mem_q[tail_q.idx] <= enq_pd;
        end
    end

endmodule
